seg_scan_mux: RTL and testbench
===============================

SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 Parameter DIV, default 50000: clk cycles per digit slot; legal range is DIV >= 2.
REQ-002 Parameter LZ_BLANK, default 1: when 1, leading zeros are blanked.
REQ-003 clk  input  1  rising-edge clock; the block has one clock only.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 value  input  16  four BCD/hex digits; [3:0] = digit0 (rightmost), [15:12] = digit3.
REQ-006 load  input  1  single-cycle request to capture value.
REQ-007 busy  output  1  high while a captured value waits for the frame boundary.
REQ-008 bcd  output  4  nibble of the current digit, fed to the downstream segment7 decoder.
REQ-009 an  output  4  active-low digit enables; at most one bit is low.
REQ-010 frame  output  1  one-cycle pulse at the end of each full 4-digit scan.

Function
REQ-011 The prescaler shall count 0..DIV-1, wrap to 0, and assert internal tick when count == DIV-1.
REQ-012 Digit index idx shall advance by 1 on tick and wrap from 3 to 0.
REQ-013 frame shall be 1 for exactly the tick cycle in which idx == 3; otherwise it shall be 0.
REQ-014 bcd and an shall be registered and shall change on the same edge as idx, with bcd = disp[idx] and an = ~(1 << idx).
REQ-015 Nibbles 0xA-0xF shall pass through unmodified; decoding is downstream.
REQ-016 If load = 1 and busy = 0, value shall be captured into pending and busy shall be 1 from the next cycle.
REQ-017 If load = 1 and busy = 1, the load shall be ignored; pending shall be unchanged and no error shall be flagged.
REQ-018 On a frame cycle with busy = 1, disp shall take pending and busy shall clear at that edge; the new digit0 slot shall show the new value.
REQ-019 If load = 1 arrives on a frame cycle with busy = 0, value shall be captured and applied at the following frame, not the concurrent one.
REQ-020 disp shall never change except per REQ-018, so no frame mixes old and new digits.
REQ-021 With LZ_BLANK = 1, digit k (k = 3..1) shall be blanked (its an bit held 1) when disp digit k and all higher digits are 0.
REQ-022 Digit0 shall never be blanked.
REQ-023 bcd shall still present the nibble during a blanked slot.
REQ-024 With LZ_BLANK = 0, blanking shall not occur.

Reset
REQ-025 While rst = 1 at a clk edge: prescaler = 0, idx = 0, disp = 0, pending = 0, busy = 0, bcd = 4'h0, an = 4'b1110, frame = 0.
REQ-026 rst mid-scan or mid-pending shall abort immediately; a pending value shall be discarded.
REQ-027 A load in the same cycle as rst shall be ignored.
REQ-028 Scanning shall restart at digit0 with a full DIV-cycle slot after rst deasserts.

Structure
REQ-029 Shared package seg_pkg shall hold NDIG = 4, DIG_W = 4, and the an one-hot-low pattern constants, for reuse by the segment7 path.
REQ-030 The prescaler shall be a sub-module, tick_gen (parameter DIV; ports clk, rst, tick).
REQ-031 All other logic shall be inline.
REQ-032 The implementation shall contain no latches and no combinational path from load to any output.

Verification (bench uses DIV = 4 and checks outputs every cycle)
REQ-033 Reset, no load, LZ_BLANK = 0 -> an cycles 1110, 1101, 1011, 0111 for 4 clk each; bcd = 0; frame pulses once every 16 clk, coincident with the 0111 -> 1110 edge.
REQ-034 Load 16'h1234 mid-scan -> busy = 1 until the next frame; then digit0 slot shows bcd = 4, an = 1110, and digit3 slot shows bcd = 1, an = 0111; busy = 0.
REQ-035 LZ_BLANK = 1, load 16'h0045 -> digit3/2 slots an = 1111; digit1 an = 1101, bcd = 4; digit0 an = 1110, bcd = 5. Load 16'h0405 -> only digit3 blanked; digit1 shows bcd = 0, an = 1101.
REQ-036 Load 16'h1234, then load 16'h9999 while busy -> the second load is ignored and the display shows 1234 for all following frames.
REQ-037 Load 16'h00A7 coincident with frame while busy = 0 -> busy stays high for 16 clk and the value appears one frame later; digit1 shows bcd = 4'hA.
REQ-038 rst pulsed during the digit2 slot with a pending value -> next cycle an = 1110, bcd = 0, busy = 0; the old pending value never appears.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the 4-digit scan path and the downstream segment7 decoder.
package seg_pkg;
  localparam int NDIG  = 4;
  localparam int DIG_W = 4;
  localparam int IDX_W = $clog2(NDIG);

  typedef logic [NDIG-1:0][DIG_W-1:0] digits_t;

  // Active-low digit enables, indexed by digit number.
  localparam logic [NDIG-1:0][NDIG-1:0] AN_SEL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
  localparam logic [NDIG-1:0]           AN_OFF = 4'b1111;

  // Bit k set when digit k and every higher digit are zero; digit0 is never blanked.
  function automatic logic [NDIG-1:0] lz_mask(input digits_t d);
    logic [NDIG-1:0] m;
    logic            z;
    m = '0;
    z = 1'b1;
    for (int k = NDIG - 1; k > 0; k--) begin
      z    = z & (d[k] == '0);
      m[k] = z;
    end
    return m;
  endfunction
endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..DIV-1 and flags the last count of each slot.
module tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) cnt <= '0;
    else             cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed 4-digit display scanner; new values swap in only at frame boundaries.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int DIV      = 50000,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NDIG*DIG_W-1:0] value,
  input  logic                  load,
  output logic                  busy,
  output logic [DIG_W-1:0]      bcd,
  output logic [NDIG-1:0]       an,
  output logic                  frame
);
  logic             tick;
  logic [IDX_W-1:0] idx, idx_nx;
  digits_t          disp, pending, disp_nx;
  logic [NDIG-1:0]  blank;

  tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign frame   = tick && (idx == IDX_W'(NDIG - 1));
  assign idx_nx  = idx + 1'b1;
  // Digit0 of a freshly swapped value must be driven on the swap edge itself.
  assign disp_nx = (frame && busy) ? pending : disp;
  assign blank   = LZ_BLANK ? lz_mask(disp_nx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      disp    <= '0;
      pending <= '0;
      busy    <= 1'b0;
      bcd     <= '0;
      an      <= AN_SEL[0];
    end else begin
      if (frame && busy) begin
        disp <= pending;
        busy <= 1'b0;
      end else if (load && !busy) begin
        pending <= value;
        busy    <= 1'b1;
      end
      if (tick) begin
        idx <= idx_nx;
        bcd <= disp_nx[idx_nx];
        an  <= blank[idx_nx] ? AN_OFF : AN_SEL[idx_nx];
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed table-driven bench for seg_scan_mux with DIV = 4, both blanking modes.
module tb_seg_scan_mux;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic        busy0, busy1, frame0, frame1;
  logic [3:0]  bcd0, bcd1, an0, an1;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  seg_scan_mux #(.DIV(4), .LZ_BLANK(1'b0)) u0 (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .busy(busy0), .bcd(bcd0), .an(an0), .frame(frame0)
  );

  seg_scan_mux #(.DIV(4), .LZ_BLANK(1'b1)) u1 (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .busy(busy1), .bcd(bcd1), .an(an1), .frame(frame1)
  );

  // kind: 0 = pulse load, 1 = pulse rst, 2 = check outputs of DUT selected by lz
  typedef struct {
    int          scen;
    int          per;
    int          kind;
    logic        lz;
    logic [15:0] val;
    logic [3:0]  an;
    logic [3:0]  bcd;
    logic        frm;
    logic        bsy;
  } vec_t;

  vec_t tv[$];

  function automatic void add_ld(int s, int p, logic [15:0] v);
    vec_t e;
    e = '{scen: s, per: p, kind: 0, lz: 1'b0, val: v, an: 4'h0, bcd: 4'h0, frm: 1'b0, bsy: 1'b0};
    tv.push_back(e);
  endfunction

  function automatic void add_rst(int s, int p);
    vec_t e;
    e = '{scen: s, per: p, kind: 1, lz: 1'b0, val: 16'h0, an: 4'h0, bcd: 4'h0, frm: 1'b0, bsy: 1'b0};
    tv.push_back(e);
  endfunction

  function automatic void add_chk(int s, int p, logic lz, logic [3:0] a, logic [3:0] b,
                                  logic f, logic bs);
    vec_t e;
    e = '{scen: s, per: p, kind: 2, lz: lz, val: 16'h0, an: a, bcd: b, frm: f, bsy: bs};
    tv.push_back(e);
  endfunction

  task automatic chk(string nm, int s, int p, logic [15:0] got, logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s scen%0d per%0d got=%h exp=%h", nm, s, p, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] an_pat [4];
    int i;
    int s;
    int p;
    an_pat = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // Scenario 0: idle scan, no blanking, 4 clk per slot, frame every 16 clk
    for (int q = 0; q < 32; q++)
      add_chk(0, q, 1'b0, an_pat[(q / 4) % 4], 4'h0, (q % 16) == 15, 1'b0);

    // Scenario 1: load 1234 mid-scan, swap at next frame
    add_ld (1, 5, 16'h1234);
    add_chk(1, 5,  1'b0, 4'b1101, 4'h0, 1'b0, 1'b0);
    add_chk(1, 6,  1'b0, 4'b1101, 4'h0, 1'b0, 1'b1);
    add_chk(1, 15, 1'b0, 4'b0111, 4'h0, 1'b1, 1'b1);
    add_chk(1, 16, 1'b0, 4'b1110, 4'h4, 1'b0, 1'b0);
    add_chk(1, 19, 1'b0, 4'b1110, 4'h4, 1'b0, 1'b0);
    add_chk(1, 20, 1'b0, 4'b1101, 4'h3, 1'b0, 1'b0);
    add_chk(1, 27, 1'b0, 4'b1011, 4'h2, 1'b0, 1'b0);
    add_chk(1, 28, 1'b0, 4'b0111, 4'h1, 1'b0, 1'b0);
    add_chk(1, 31, 1'b0, 4'b0111, 4'h1, 1'b1, 1'b0);
    add_chk(1, 32, 1'b0, 4'b1110, 4'h4, 1'b0, 1'b0);

    // Scenario 2: leading-zero blanking, 0045 then 0405
    add_ld (2, 2, 16'h0045);
    add_chk(2, 2,  1'b1, 4'b1110, 4'h0, 1'b0, 1'b0);
    add_chk(2, 4,  1'b1, 4'b1111, 4'h0, 1'b0, 1'b1);
    add_chk(2, 15, 1'b1, 4'b1111, 4'h0, 1'b1, 1'b1);
    add_chk(2, 16, 1'b1, 4'b1110, 4'h5, 1'b0, 1'b0);
    add_chk(2, 20, 1'b1, 4'b1101, 4'h4, 1'b0, 1'b0);
    add_chk(2, 24, 1'b1, 4'b1111, 4'h0, 1'b0, 1'b0);
    add_chk(2, 28, 1'b1, 4'b1111, 4'h0, 1'b0, 1'b0);
    add_chk(2, 31, 1'b1, 4'b1111, 4'h0, 1'b1, 1'b0);
    add_ld (2, 33, 16'h0405);
    add_chk(2, 34, 1'b1, 4'b1110, 4'h5, 1'b0, 1'b1);
    add_chk(2, 48, 1'b1, 4'b1110, 4'h5, 1'b0, 1'b0);
    add_chk(2, 52, 1'b1, 4'b1101, 4'h0, 1'b0, 1'b0);
    add_chk(2, 56, 1'b1, 4'b1011, 4'h4, 1'b0, 1'b0);
    add_chk(2, 60, 1'b1, 4'b1111, 4'h0, 1'b0, 1'b0);
    add_chk(2, 63, 1'b1, 4'b1111, 4'h0, 1'b1, 1'b0);

    // Scenario 3: second load while busy is dropped
    add_ld (3, 1, 16'h1234);
    add_ld (3, 3, 16'h9999);
    add_chk(3, 4,  1'b0, 4'b1101, 4'h0, 1'b0, 1'b1);
    add_chk(3, 16, 1'b0, 4'b1110, 4'h4, 1'b0, 1'b0);
    add_chk(3, 28, 1'b0, 4'b0111, 4'h1, 1'b0, 1'b0);
    add_chk(3, 32, 1'b0, 4'b1110, 4'h4, 1'b0, 1'b0);
    add_chk(3, 44, 1'b0, 4'b0111, 4'h1, 1'b0, 1'b0);
    add_chk(3, 60, 1'b0, 4'b0111, 4'h1, 1'b0, 1'b0);

    // Scenario 4: load on an idle frame cycle lands one frame later
    add_ld (4, 15, 16'h00A7);
    add_chk(4, 15, 1'b1, 4'b1111, 4'h0, 1'b1, 1'b0);
    add_chk(4, 16, 1'b1, 4'b1110, 4'h0, 1'b0, 1'b1);
    add_chk(4, 31, 1'b1, 4'b1111, 4'h0, 1'b1, 1'b1);
    add_chk(4, 32, 1'b1, 4'b1110, 4'h7, 1'b0, 1'b0);
    add_chk(4, 36, 1'b1, 4'b1101, 4'hA, 1'b0, 1'b0);
    add_chk(4, 40, 1'b1, 4'b1111, 4'h0, 1'b0, 1'b0);

    // Scenario 5: rst in digit2 slot with pending value (and a load alongside rst)
    add_ld (5, 1, 16'h1234);
    add_chk(5, 9,  1'b0, 4'b1011, 4'h0, 1'b0, 1'b1);
    add_rst(5, 9);
    add_ld (5, 9, 16'h5555);
    add_chk(5, 10, 1'b0, 4'b1110, 4'h0, 1'b0, 1'b0);
    add_chk(5, 13, 1'b0, 4'b1110, 4'h0, 1'b0, 1'b0);
    add_chk(5, 14, 1'b0, 4'b1101, 4'h0, 1'b0, 1'b0);
    add_chk(5, 25, 1'b0, 4'b0111, 4'h0, 1'b1, 1'b0);
    add_chk(5, 26, 1'b0, 4'b1110, 4'h0, 1'b0, 1'b0);
    add_chk(5, 38, 1'b0, 4'b0111, 4'h0, 1'b0, 1'b0);

    i = 0;
    while (i < tv.size()) begin
      s = tv[i].scen;
      load = 1'b0;
      rst  = 1'b1;
      cyc();
      rst  = 1'b0;
      p = 0;
      while (i < tv.size() && tv[i].scen == s) begin
        load = 1'b0;
        rst  = 1'b0;
        while (i < tv.size() && tv[i].scen == s && tv[i].per == p) begin
          case (tv[i].kind)
            0: begin load = 1'b1; value = tv[i].val; end
            1: rst = 1'b1;
            default: begin
              if (tv[i].lz) begin
                chk("an",    s, p, 16'(an1),    16'(tv[i].an));
                chk("bcd",   s, p, 16'(bcd1),   16'(tv[i].bcd));
                chk("frame", s, p, 16'(frame1), 16'(tv[i].frm));
                chk("busy",  s, p, 16'(busy1),  16'(tv[i].bsy));
              end else begin
                chk("an",    s, p, 16'(an0),    16'(tv[i].an));
                chk("bcd",   s, p, 16'(bcd0),   16'(tv[i].bcd));
                chk("frame", s, p, 16'(frame0), 16'(tv[i].frm));
                chk("busy",  s, p, 16'(busy0),  16'(tv[i].bsy));
              end
            end
          endcase
          i++;
        end
        cyc();
        p++;
      end
    end

    // Hold rst high over several edges: state must sit at reset values
    load  = 1'b1;
    value = 16'hFFFF;
    rst   = 1'b1;
    cyc();
    cyc();
    load = 1'b0;
    chk("rst_an",    9, 0, 16'(an0),    16'(4'b1110));
    chk("rst_bcd",   9, 0, 16'(bcd0),   16'h0);
    chk("rst_busy",  9, 0, 16'(busy1),  16'h0);
    chk("rst_frame", 9, 0, 16'(frame1), 16'h0);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
